// File: rtl/horse_lights_pkg.sv
// rtl/horse_lights_pkg.sv - shared types and constants for the running-light sequencer
package horse_lights_pkg;

    typedef enum logic [1:0] {
        MODE_FILL    = 2'd0,
        MODE_SPLIT   = 2'd1,
        MODE_SERIAL  = 2'd2,
        MODE_ROTATE  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Steps per pass for each mode; the serial mode adds its hold time on top.
    localparam int LEN_FILL        = 16;
    localparam int LEN_SPLIT       = 8;
    localparam int LEN_SERIAL_BASE = 8;
    localparam int LEN_ROTATE      = 8;

    localparam logic [7:0] SERIAL_SEQ = 8'b11110000;
    localparam logic [7:0] ROT_SEED   = 8'b11000000;

    // Index of the final step of a pass in mode m.
    function automatic logic [4:0] last_step(mode_e m, int hold_steps);
        case (m)
            MODE_FILL:   return 5'(LEN_FILL - 1);
            MODE_SPLIT:  return 5'(LEN_SPLIT - 1);
            MODE_SERIAL: return 5'(LEN_SERIAL_BASE + hold_steps - 1);
            default:     return 5'(LEN_ROTATE - 1);
        endcase
    endfunction

endpackage

// File: rtl/horse_lights_sched_if.sv
// rtl/horse_lights_sched_if.sv - control and lamp bus between switches/keys and the sequencer
interface horse_lights_sched_if #(
    parameter int PASS_W = 1
) ();
    logic              start;
    logic              stop;
    logic              auto;
    logic [1:0]        S;
    logic [7:0]        Y;
    logic [1:0]        mode;
    logic [PASS_W-1:0] pass;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, auto, S,
        input  Y, mode, pass, busy, done
    );

    modport slave (
        input  start, stop, auto, S,
        output Y, mode, pass, busy, done
    );
endinterface

// File: rtl/horse_pattern_rom.sv
// rtl/horse_pattern_rom.sv - combinational lamp pattern lookup by mode and step
module horse_pattern_rom
    import horse_lights_pkg::*;
(
    input  mode_e      mode_i,
    input  logic [4:0] step_i,
    output logic [7:0] y_o
);

    // Pattern for the given step; Y[7] is the leftmost lamp.
    always_comb begin
        y_o = 8'h00;
        case (mode_i)
            MODE_FILL: begin
                // Fill from the left, then drain from the left.
                if (step_i < 5'd8) y_o = ~(8'hFF >> (step_i + 5'd1));
                else               y_o = 8'hFF >> (step_i - 5'd7);
            end
            MODE_SPLIT: begin
                case (step_i[2:0])
                    3'd0:    y_o = 8'b10000001;
                    3'd1:    y_o = 8'b11000011;
                    3'd2:    y_o = 8'b11100111;
                    3'd3:    y_o = 8'b11111111;
                    3'd4:    y_o = 8'b01111110;
                    3'd5:    y_o = 8'b00111100;
                    3'd6:    y_o = 8'b00011000;
                    default: y_o = 8'b00000000;
                endcase
            end
            MODE_SERIAL: begin
                // Sequence shifts in one lamp per step, then is held whole.
                if (step_i < 5'd8) y_o = SERIAL_SEQ & ~(8'hFF >> (step_i + 5'd1));
                else               y_o = SERIAL_SEQ;
            end
            default: begin
                // Rotate right; a left shift of 8 contributes nothing at step 0.
                y_o = (ROT_SEED >> step_i[2:0]) | (ROT_SEED << (4'd8 - {1'b0, step_i[2:0]}));
            end
        endcase
    end

endmodule

// File: rtl/horse_lights_sched.sv
// rtl/horse_lights_sched.sv - running-light sequencer: step prescaler, mode/pass FSM, lamp register
module horse_lights_sched
    import horse_lights_pkg::*;
#(
    parameter int TICK_DIV   = 25_000_000,
    parameter int REPEAT     = 2,
    parameter int HOLD_STEPS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    horse_lights_sched_if.slave   bus
);

    localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(REPEAT - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);

    state_e            state_q, state_d;
    mode_e             mode_q,  mode_d;
    logic [PASS_W-1:0] pass_q,  pass_d;
    logic [4:0]        step_q,  step_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              auto_q,  auto_d;
    logic              done_q,  done_d;
    logic [7:0]        y_q,     y_d;
    logic [7:0]        rom_y;
    logic              tick;

    assign tick = (cnt_q == CNT_LAST);

    // Looks up the pattern of the next step so the lamp register updates with the step.
    horse_pattern_rom u_rom (
        .mode_i (mode_d),
        .step_i (step_d),
        .y_o    (rom_y)
    );

    // State, counters and lamp register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_FILL;
            pass_q  <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            auto_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pass_q  <= pass_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            auto_q  <= auto_d;
            done_q  <= done_d;
            y_q     <= y_d;
        end
    end

    // Next-state: start acceptance, per-tick step/pass/mode advance, abort and completion.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pass_d  = pass_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        auto_d  = auto_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = ST_RUN;
                    auto_d  = bus.auto;
                    mode_d  = bus.auto ? MODE_FILL : mode_e'(bus.S);
                    pass_d  = '0;
                    step_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (!tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (step_q != last_step(mode_q, HOLD_STEPS)) begin
                        step_d = step_q + 5'd1;
                    end else if (pass_q != PASS_LAST) begin
                        pass_d = pass_q + PASS_W'(1);
                        step_d = '0;
                    end else if (auto_q && mode_q != MODE_ROTATE) begin
                        mode_d = mode_e'(mode_q + 2'd1);
                        pass_d = '0;
                        step_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    // Lamps are dark whenever the sequencer is (or is about to be) idle.
    always_comb begin
        y_d = (state_d == ST_RUN) ? rom_y : 8'h00;
    end

    assign bus.Y    = y_q;
    assign bus.mode = mode_q;
    assign bus.pass = pass_q;
    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = done_q;

endmodule

// File: tb/tb_horse_lights_sched.sv
// tb/tb_horse_lights_sched.sv - randomized self-checking bench for horse_lights_sched
module tb_horse_lights_sched;

    localparam int TICK_DIV   = 4;
    localparam int REPEAT     = 2;
    localparam int HOLD_STEPS = 4;
    localparam int PASS_W     = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    logic clk = 1'b0;
    logic reset;

    horse_lights_sched_if #(.PASS_W(PASS_W)) bus ();

    horse_lights_sched #(
        .TICK_DIV   (TICK_DIV),
        .REPEAT     (REPEAT),
        .HOLD_STEPS (HOLD_STEPS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] y;
        int         m;
        int         p;
    } step_t;

    step_t plan[$];
    int    len_of[4] = '{16, 8, 8 + HOLD_STEPS, 8};

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Lamp picture for mode m, step k, described lamp by lamp (j counts from the left).
    function automatic logic [7:0] ref_lamps(input int m, input int k);
        logic [7:0] y;
        y = 8'h00;
        for (int j = 0; j < 8; j++) begin
            bit lit;
            case (m)
                0:       lit = (k < 8) ? (j <= k) : (j >= k - 7);
                1:       lit = (k < 4) ? (j <= k || j >= 7 - k) : (j >= k - 3 && j <= 10 - k);
                2:       lit = (j < 4) && (k >= 8 || j <= k);
                default: lit = (j == k % 8) || (j == (k + 1) % 8);
            endcase
            y[7 - j] = lit;
        end
        return y;
    endfunction

    task automatic build_plan(input bit au, input int s);
        int m_first;
        int m_last;
        plan.delete();
        m_first = au ? 0 : s;
        m_last  = au ? 3 : s;
        for (int m = m_first; m <= m_last; m++)
            for (int p = 0; p < REPEAT; p++)
                for (int k = 0; k < len_of[m]; k++)
                    plan.push_back('{ref_lamps(m, k), m, p});
    endtask

    // abort_kind: 0 none, 1 stop, 2 reset, applied at cycle abort_cycle after acceptance.
    task automatic do_run(input bit au, input int s, input int abort_kind,
                          input int abort_cycle, input bit disturb);
        int total;
        int c;
        int idx;
        bit ended;
        build_plan(au, s);
        total = plan.size() * TICK_DIV;
        @(negedge clk);
        bus.start = 1'b1;
        bus.auto  = au;
        bus.S     = 2'(s);
        @(negedge clk);
        bus.start = 1'b0;
        c = 1;
        ended = 1'b0;
        while (!ended) begin
            if (c <= total) begin
                idx = (c - 1) / TICK_DIV;
                expect_eq("Y",    32'(bus.Y),    32'(plan[idx].y));
                expect_eq("mode", 32'(bus.mode), 32'(plan[idx].m));
                expect_eq("pass", 32'(bus.pass), 32'(plan[idx].p));
                expect_eq("busy", 32'(bus.busy), 32'd1);
                expect_eq("done", 32'(bus.done), 32'd0);
            end else begin
                expect_eq("end_Y",    32'(bus.Y),    32'd0);
                expect_eq("end_busy", 32'(bus.busy), 32'd0);
                expect_eq("end_done", 32'(bus.done), 32'd1);
                ended = 1'b1;
            end
            if (!ended && abort_kind != 0 && c == abort_cycle) begin
                if (abort_kind == 1) bus.stop = 1'b1;
                else                 reset    = 1'b1;
                @(negedge clk);
                bus.stop = 1'b0;
                reset    = 1'b0;
                expect_eq("abort_Y",    32'(bus.Y),    32'd0);
                expect_eq("abort_busy", 32'(bus.busy), 32'd0);
                expect_eq("abort_done", 32'(bus.done), 32'd0);
                if (abort_kind == 2) begin
                    expect_eq("rst_mode", 32'(bus.mode), 32'd0);
                    expect_eq("rst_pass", 32'(bus.pass), 32'd0);
                end
                ended = 1'b1;
            end else if (!ended) begin
                if (disturb) begin
                    bus.start = 1'($urandom);
                    bus.auto  = 1'($urandom);
                    bus.S     = 2'($urandom);
                end
                @(negedge clk);
                c++;
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        expect_eq("idle_Y",    32'(bus.Y),    32'd0);
        expect_eq("idle_busy", 32'(bus.busy), 32'd0);
        expect_eq("idle_done", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.auto  = 1'b0;
        bus.S     = 2'd0;
        repeat (3) @(negedge clk);
        expect_eq("reset_Y",    32'(bus.Y),    32'd0);
        expect_eq("reset_mode", 32'(bus.mode), 32'd0);
        expect_eq("reset_pass", 32'(bus.pass), 32'd0);
        expect_eq("reset_busy", 32'(bus.busy), 32'd0);
        expect_eq("reset_done", 32'(bus.done), 32'd0);
        reset = 1'b0;

        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        expect_eq("startstop_busy", 32'(bus.busy), 32'd0);
        expect_eq("startstop_Y",    32'(bus.Y),    32'd0);
        @(negedge clk);
        expect_eq("startstop_busy2", 32'(bus.busy), 32'd0);

        do_run(1'b1, 0, 0, 0, 1'b0);
        do_run(1'b0, 2, 0, 0, 1'b1);
        do_run(1'b0, 1, 1, 21 + int'($urandom_range(0, 3)), 1'b1);
        do_run(1'b0, 1, 0, 0, 1'b0);
        do_run(1'b0, 3, 2, 1 + int'($urandom_range(0, 31)), 1'b0);
        do_run(1'b1, 0, 2, 300 + int'($urandom_range(0, 40)), 1'b1);

        for (int r = 0; r < 8; r++) begin
            do_run(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   1 + int'($urandom_range(0, 60)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/horse_lights_sched.md
Name: horse_lights_sched

Overview:
- Sequencer for the 8-lamp running-light bank: owns lamp timing, mode order and repeat count, and drives Y directly.
- Replaces delay-based stepping with a clock-divided step tick and an explicit FSM.
- Auto mode runs modes 0→1→2→3, each REPEAT times, then stops. Manual mode runs only the mode selected by S.
- Sits between board switches/keys and the LED pins.

Parameters:
- TICK_DIV, 25_000_000, clk cycles per lamp step (0.5 s at 50 MHz).
- REPEAT, 2, passes per mode (≥1).
- HOLD_STEPS, 4, step ticks the mode-2 final pattern is held.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock, no other clock domains.
- start  in  1  level-sampled request; accepted only in IDLE.
- stop  in  1  abort request; returns to IDLE.
- auto  in  1  1 = all four modes in order; 0 = mode S only. Sampled at start.
- S  in  2  mode select for manual run. Sampled at start.
- Y  out  8  lamp outputs; Y[7] is the leftmost lamp; 1 = lit.
- mode  out  2  mode currently running.
- pass  out  $clog2(REPEAT)  current pass index.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a run completes normally.

Behaviour:
- Reset (synchronous): state=IDLE, Y=0, mode=0, pass=0, step=0, prescaler=0, busy=0, done=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN and is cleared on start acceptance.
  - tick = (count==TICK_DIV-1).
  - Every step is held exactly TICK_DIV cycles.
- States: IDLE, RUN. Completion is flagged by the done pulse on the RUN→IDLE edge; there is no separate DONE state.
- IDLE:
  - Y=0.
  - On start with stop=0: mode = auto ? 0 : S; pass=0; step=0; busy=1.
  - Y=pattern(mode,0) is registered at the same edge, so the first pattern is visible 1 cycle after start.
- RUN, per tick:
  - If step < LEN(mode)-1: step++ and Y=pattern(mode,step+1).
  - Else, if pass < REPEAT-1: pass++, step=0.
  - Else, if auto and mode<3: mode++, pass=0, step=0.
  - Otherwise: go to IDLE, Y=0, busy=0, done=1 for that one cycle.
- Step lengths: LEN = 16, 8, 8+HOLD_STEPS, 8 for modes 0–3.
- Patterns, step k:
  - Mode 0: k<8 → ~(8'hFF>>(k+1)), so 10000000..11111111. k≥8 → 8'hFF>>(k-7), so 01111111..00000000.
  - Mode 1: 10000001, 11000011, 11100111, 11111111, 01111110, 00111100, 00011000, 00000000.
  - Mode 2: serial entry of sequence 11110000, one lamp per step, left to right. Steps 0–7: 10000000, 11000000, 11100000, 11110000, then 11110000 (lamps 5–8 dark) for steps 4–7. Steps 8..8+HOLD_STEPS-1: all eight shown at once, 11110000, held.
  - Mode 3: pair of lit lamps rotating right. Y = 11000000 rotated right by k; step 7 = 10000001.
- Boundary conditions:
  - start while RUN: ignored.
  - S and auto changing during RUN: ignored.
  - stop in RUN: IDLE next edge, Y=0, busy=0, no done.
  - stop and start in the same cycle in IDLE: stop wins; remain IDLE.
  - reset mid-run: full reset values at the next edge.
  - REPEAT=1: a single pass per mode.
- Timing budget: an auto run takes 2×(40+HOLD_STEPS)×TICK_DIV cycles. This is 88 steps = 44 s at defaults, which must be ≤120 s.

Decomposition:
- horse_lights_pkg holds:
  - mode encodings MODE_FILL=0, MODE_SPLIT=1, MODE_SERIAL=2, MODE_ROTATE=3;
  - the LEN constants;
  - SERIAL_SEQ=8'b11110000 and ROT_SEED=8'b11000000.
- Sub-module horse_pattern_rom: purely combinational, maps (mode, step[4:0]) → Y[7:0]. The FSM registers its output.

Test Plan (TICK_DIV=4, REPEAT=2, HOLD_STEPS=4):
- reset held 3 cycles, then start=1 with auto=1 → Y=10000000 at start+1; Y=11000000 at start+5; mode=1 after 32 ticks.
- Full auto run → mode sequence 0,1,2,3. done pulses exactly once at cycle start+1+88×4 with Y=00000000 and busy=0.
- auto=0, S=2 → after step 3 Y=11110000 holds through step 11; pass toggles 0→1; done after 24 ticks.
- stop asserted at step 5 of mode 1 → Y=00000000 and busy=0 next cycle; no done. A subsequent start restarts at step 0.
- start pulsed again mid-run, and S changed mid-run → no effect on mode, step or pass.
- reset asserted mid-mode-3 → all outputs at reset values on the next edge. stop=start=1 together in IDLE → stays IDLE.
